// File: rtl/param_alu_mdu.sv
// Parametrised EX-stage ALU with an iterative radix-2 multiply/divide unit.
// Single-cycle ops are combinational; MULT/DIV results land in hi/lo.
module param_alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             carry,
    output logic             neg,
    output logic             zero,
    output logic             busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};

    localparam logic [3:0] OP_SLL = 4'd0, OP_SRL = 4'd1, OP_SRA = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3, OP_SUB = 4'd4, OP_AND = 4'd5;
    localparam logic [3:0] OP_OR = 4'd6, OP_XOR = 4'd7, OP_NOR = 4'd8;
    localparam logic [3:0] OP_SLT = 4'd9, OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MULTU = 4'd11, OP_MULT = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13, OP_DIV = 4'd14;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state, state_n;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] m, acc, q;
    logic             sgn_p, sgn_r;

    logic             sub_op, add_ovf;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res;

    assign sub_op = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    assign bx = sub_op ? ~b : b;
    assign sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub_op};
    assign add_ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign shamt = b[SHW-1:0];

    always_comb begin
        res = a;
        unique case (op)
            OP_SLL:  res = a << shamt;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = WIDTH'($signed(a) >>> shamt);
            OP_ADD:  res = sum[WIDTH-1:0];
            OP_SUB:  res = sum[WIDTH-1:0];
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
            default: res = a;
        endcase
    end

    assign result = res;
    assign ovf = add_ovf && ((op == OP_ADD) || (op == OP_SUB));
    assign carry = sum[WIDTH];
    assign neg = sum[WIDTH-1];
    assign zero = (res == '0);

    logic             is_md, is_mul, signed_op, div_zero, accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign is_md = (op == OP_MULTU) || (op == OP_MULT) ||
                   (op == OP_DIVU) || (op == OP_DIV);
    assign is_mul = (op == OP_MULTU) || (op == OP_MULT);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign div_zero = !is_mul && (b == '0);
    assign accept = in_valid && (state == IDLE) && is_md && !flush;
    assign a_neg = signed_op && a[WIDTH-1];
    assign b_neg = signed_op && b[WIDTH-1];
    assign a_abs = a_neg ? ({WIDTH{1'b0}} - a) : a;
    assign b_abs = b_neg ? ({WIDTH{1'b0}} - b) : b;

    // One iteration: shift-add for MUL, restoring subtract for DIV.
    logic [WIDTH:0]     madd, rsh, dif;
    logic               ge;
    logic [WIDTH-1:0]   acc_n, q_n;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        madd = {1'b0, acc} + ({1'b0, m} & {(WIDTH+1){q[0]}});
        rsh = {acc, q[WIDTH-1]};
        dif = rsh - {1'b0, m};
        ge = !dif[WIDTH];
        acc_n = madd[WIDTH:1];
        q_n = {madd[0], q[WIDTH-1:1]};
        if (state == DIV) begin
            acc_n = ge ? dif[WIDTH-1:0] : rsh[WIDTH-1:0];
            q_n = {q[WIDTH-2:0], ge};
        end
        prod = {acc_n, q_n};
        prod_s = sgn_p ? ({(2*WIDTH){1'b0}} - prod) : prod;
        quo = sgn_p ? ({WIDTH{1'b0}} - q_n) : q_n;
        rem = sgn_r ? ({WIDTH{1'b0}} - acc_n) : acc_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept) state_n = div_zero ? DONE : (is_mul ? MUL : DIV);
            MUL:  if (cnt == CNT_ONE) state_n = DONE;
            DIV:  if (cnt == CNT_ONE) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            cnt   <= '0;
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            sgn_p <= 1'b0;
            sgn_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                m     <= b_abs;
                acc   <= '0;
                q     <= a_abs;
                cnt   <= CNT_INIT;
                sgn_p <= a_neg ^ b_neg;
                sgn_r <= a_neg;
                if (div_zero) begin
                    cnt <= '0;
                    hi  <= a;
                    lo  <= '1;
                end
            end else if ((state == MUL || state == DIV) && !flush) begin
                acc <= acc_n;
                q   <= q_n;
                cnt <= cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    if (state == MUL) begin
                        hi <= prod_s[2*WIDTH-1:WIDTH];
                        lo <= prod_s[WIDTH-1:0];
                    end else begin
                        hi <= rem;
                        lo <= quo;
                    end
                end
            end
        end
    end

    assign in_ready = (state == IDLE);
    assign busy = (state != IDLE);
    assign md_done = (state == DONE);
endmodule

// File: tb/tb_param_alu_mdu.sv
// Directed bench for param_alu_mdu at WIDTH=32 and WIDTH=8.
module tb_param_alu_mdu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst32, iv32, fl32, rdy32, ovf32, cy32, neg32, z32, bsy32, md32;
    logic [3:0]  op32;
    logic [31:0] a32, b32, res32, hi32, lo32;

    logic        nrst8, iv8, fl8, rdy8, ovf8, cy8, neg8, z8, bsy8, md8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, res8, hi8, lo8;

    int total = 0;
    int passed = 0;

    param_alu_mdu #(.WIDTH(32)) u32 (
        .CLK(clk), .nRST(nrst32), .in_valid(iv32), .op(op32), .a(a32), .b(b32),
        .flush(fl32), .in_ready(rdy32), .result(res32), .ovf(ovf32), .carry(cy32),
        .neg(neg32), .zero(z32), .busy(bsy32), .md_done(md32), .hi(hi32), .lo(lo32)
    );

    param_alu_mdu #(.WIDTH(8)) u8 (
        .CLK(clk), .nRST(nrst8), .in_valid(iv8), .op(op8), .a(a8), .b(b8),
        .flush(fl8), .in_ready(rdy8), .result(res8), .ovf(ovf8), .carry(cy8),
        .neg(neg8), .zero(z8), .busy(bsy8), .md_done(md8), .hi(hi8), .lo(lo8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called in the accept cycle; returns after md_done is seen or the bound expires.
    task automatic wait_done(input bit w8, input int expn, input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if (w8) iv8 = 1'b0;
                else iv32 = 1'b0;
            end
            #1;
            seen = w8 ? md8 : md32;
        end
        chk(tag, 64'(n), 64'(expn));
    endtask

    task automatic go32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        iv32 = 1'b1; op32 = o; a32 = x; b32 = y;
    endtask

    initial begin
        nrst32 = 1'b0; iv32 = 1'b0; fl32 = 1'b0; op32 = 4'd15; a32 = '0; b32 = '0;
        nrst8 = 1'b0; iv8 = 1'b0; fl8 = 1'b0; op8 = 4'd15; a8 = '0; b8 = '0;
        @(negedge clk);
        @(negedge clk);
        nrst32 = 1'b1; nrst8 = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_hi", 64'(hi32), 64'h0);
        chk("rst_lo", 64'(lo32), 64'h0);
        chk("rst_busy", 64'(bsy32), 64'h0);
        chk("rst_ready", 64'(rdy32), 64'h1);
        chk("rst_done", 64'(md32), 64'h0);
        chk("rst8_ready", 64'(rdy8), 64'h1);

        a32 = 32'h8000_0001; op32 = 4'd0; b32 = 32'd4; #1;
        chk("sll", 64'(res32), 64'h0000_0010);
        op32 = 4'd1; b32 = 32'd36; #1;
        chk("srl", 64'(res32), 64'h0800_0000);
        op32 = 4'd2; b32 = 32'd4; #1;
        chk("sra", 64'(res32), 64'hF800_0000);
        op32 = 4'd2; b32 = 32'd0; #1;
        chk("sra0", 64'(res32), 64'h8000_0001);
        chk("shift_busy", 64'(bsy32), 64'h0);
        op32 = 4'd3; a32 = 32'h7FFF_FFFF; b32 = 32'd1; #1;
        chk("add_res", 64'(res32), 64'h8000_0000);
        chk("add_ovf", 64'(ovf32), 64'h1);
        chk("add_neg", 64'(neg32), 64'h1);
        op32 = 4'd10; a32 = 32'd1; b32 = 32'hFFFF_FFFF; #1;
        chk("sltu", 64'(res32), 64'h1);
        op32 = 4'd9; #1;
        chk("slt", 64'(res32), 64'h0);
        chk("slt_ovf", 64'(ovf32), 64'h0);
        op32 = 4'd4; a32 = 32'd5; b32 = 32'd5; #1;
        chk("sub_zero", 64'(z32), 64'h1);
        chk("sub_carry", 64'(cy32), 64'h1);
        op32 = 4'd8; a32 = 32'h0F0F_0000; b32 = 32'h0000_F0F0; #1;
        chk("nor", 64'(res32), 64'hF0F0_0F0F);

        go32(4'd12, 32'hFFFF_FFFD, 32'd7);
        #1;
        chk("mult_c0_res", 64'(res32), 64'hFFFF_FFFD);
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 1) iv32 = 1'b0;
            if (c == 5) begin
                iv32 = 1'b1; op32 = 4'd11; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
            end
            #1;
            chk($sformatf("mult_busy_c%0d", c), 64'(bsy32), 64'h1);
            chk($sformatf("mult_rdy_c%0d", c), 64'(rdy32), 64'h0);
            chk($sformatf("mult_done_c%0d", c), 64'(md32), 64'(c == 33));
        end
        chk("mult_hi", 64'(hi32), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo32), 64'hFFFF_FFEB);
        @(negedge clk);
        #1;
        chk("c34_ready", 64'(rdy32), 64'h1);
        chk("c34_hi_kept", 64'(hi32), 64'hFFFF_FFFF);
        wait_done(1'b0, 33, "multu_lat");
        chk("multu_hi", 64'(hi32), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo32), 64'h0000_0001);

        go32(4'd14, 32'hFFFF_FFF9, 32'd2);
        wait_done(1'b0, 33, "div_lat");
        chk("div_lo", 64'(lo32), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi32), 64'hFFFF_FFFF);

        go32(4'd13, 32'd5, 32'd0);
        wait_done(1'b0, 1, "div0_lat");
        chk("div0_lo", 64'(lo32), 64'hFFFF_FFFF);
        chk("div0_hi", 64'(hi32), 64'h5);

        go32(4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1'b0, 33, "divmin_lat");
        chk("divmin_lo", 64'(lo32), 64'h8000_0000);
        chk("divmin_hi", 64'(hi32), 64'h0);

        go32(4'd13, 32'd100, 32'd7);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) iv32 = 1'b0;
            if (c == 10) fl32 = 1'b1;
            #1;
            chk($sformatf("fl_busy_c%0d", c), 64'(bsy32), 64'h1);
        end
        @(negedge clk);
        fl32 = 1'b0;
        #1;
        chk("fl_idle", 64'(rdy32), 64'h1);
        chk("fl_done", 64'(md32), 64'h0);
        chk("fl_lo_kept", 64'(lo32), 64'h8000_0000);
        chk("fl_hi_kept", 64'(hi32), 64'h0);
        iv32 = 1'b1; op32 = 4'd13; a32 = 32'd100; b32 = 32'd7;
        wait_done(1'b0, 33, "divu_lat");
        chk("divu_lo", 64'(lo32), 64'd14);
        chk("divu_hi", 64'(hi32), 64'd2);

        go32(4'd11, 32'd2, 32'd3);
        fl32 = 1'b1;
        @(negedge clk);
        iv32 = 1'b0; fl32 = 1'b0;
        #1;
        chk("fl_acc_busy", 64'(bsy32), 64'h0);
        @(negedge clk);
        #1;
        chk("fl_acc_done", 64'(md32), 64'h0);
        chk("fl_acc_lo", 64'(lo32), 64'd14);

        @(negedge clk);
        op8 = 4'd2; a8 = 8'h81; b8 = 8'h0C; #1;
        chk("w8_sra", 64'(res8), 64'hF8);
        iv8 = 1'b1; op8 = 4'd11; a8 = 8'hFF; b8 = 8'hFF;
        wait_done(1'b1, 9, "w8_multu_lat");
        chk("w8_hi", 64'(hi8), 64'hFE);
        chk("w8_lo", 64'(lo8), 64'h01);

        @(negedge clk);
        iv8 = 1'b1; op8 = 4'd12; a8 = 8'd3; b8 = 8'd5;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) iv8 = 1'b0;
            if (c == 4) nrst8 = 1'b0;
            #1;
            chk($sformatf("w8_busy_c%0d", c), 64'(bsy8), 64'h1);
        end
        @(negedge clk);
        nrst8 = 1'b1;
        #1;
        chk("w8_rst_hi", 64'(hi8), 64'h0);
        chk("w8_rst_lo", 64'(lo8), 64'h0);
        chk("w8_rst_ready", 64'(rdy8), 64'h1);
        chk("w8_rst_busy", 64'(bsy8), 64'h0);
        repeat (12) @(negedge clk);
        #1;
        chk("w8_rst_nodone", 64'(md8), 64'h0);
        chk("w8_rst_lo_kept", 64'(lo8), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/param_alu_mdu.md
Name: param_alu_mdu

Overview:
- Parametrised successor to the single-cycle execute-stage ALU.
- Keeps all single-cycle logic, shift and compare operations, generalised to WIDTH bits, and adds arithmetic right shift.
- Adds an iterative multiply/divide unit (radix-2) with HI/LO result registers, a ready/valid issue handshake and flush support.
- Sits in the EX stage; the hazard unit stalls on in_ready and busy.

Parameters:
WIDTH, 32, datapath width in bits; power of two, at least 8. Local SHW = $clog2(WIDTH).

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
in_valid  in  1  operation presented this cycle
op  in  4  operation code (see Behaviour)
a  in  WIDTH  operand 1 (for shifts: value to shift)
b  in  WIDTH  operand 2 (for shifts: amount in b[SHW-1:0])
flush  in  1  abort any multi-cycle operation in flight
in_ready  out  1  unit can accept a multi-cycle op this cycle
result  out  WIDTH  single-cycle result (combinational)
ovf  out  1  signed overflow (ADD/SUB only, else 0)
carry  out  1  adder carry-out
neg  out  1  adder result MSB
zero  out  1  result == 0
busy  out  1  multi-cycle operation in progress
md_done  out  1  one-cycle pulse: hi/lo hold the new product or quotient
hi  out  WIDTH  HI register (product upper half / remainder)
lo  out  WIDTH  LO register (product lower half / quotient)

Behaviour:
- op codes:
  - 0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOR
  - 9 SLT, 10 SLTU (result zero-extended 0/1)
  - 11 MULTU, 12 MULT, 13 DIVU, 14 DIV
  - 15 PASS (result = a)
- Single-cycle ops (0-10, 15):
  - result and flags are combinational from a, b, op, independent of in_valid and FSM state; never stalled by busy.
  - Shifts use only b[SHW-1:0]; a shift amount of 0 returns a.
- Adder:
  - SUB/SLT/SLTU compute a + ~b + 1. carry = carry-out (1 means no borrow).
  - SLT = neg XOR ovf. SLTU = NOT carry.
- For multi-cycle ops (11-14), result = a and flags are computed as for PASS.
- FSM states: IDLE, MUL, DIV, DONE. in_ready = (state==IDLE). busy = (state!=IDLE).
- Accept:
  - Occurs when in_valid & in_ready & op in 11..14 & !flush.
  - Latch operands.
  - Signed ops take absolute values and record the result signs.
  - Load a WIDTH-cycle iteration counter. Next state MUL or DIV.
- MUL/DIV:
  - One shift-add or restoring-subtract step per cycle, for exactly WIDTH cycles.
  - After the last step, sign-correct and write hi/lo at that edge. Next state DONE.
- DONE: md_done=1 for one cycle; next state IDLE.
- Timing:
  - Op accepted in cycle 0 → md_done in cycle WIDTH+1.
  - Earliest next multi-cycle accept is cycle WIDTH+2.
- Signed results:
  - Signed MULT negates the 2*WIDTH-bit product when operand signs differ.
  - Signed DIV: quotient is negative iff signs differ; remainder takes the sign of a.
- Divide by zero (b==0, DIVU or DIV):
  - Skip iteration: accept → DONE next cycle.
  - lo = all ones, hi = a.
- DIV of most-negative by −1: lo = most-negative, hi = 0, no flag.
- Multi-cycle op presented while busy: not accepted; hi/lo and in-flight op unaffected. Requester holds in_valid/op/a/b.
- flush:
  - Any state → IDLE next cycle.
  - hi/lo keep their pre-op values; md_done is not asserted.
  - flush with a same-cycle accept: flush wins, nothing accepted.
- Reset (nRST=0 at edge): state IDLE, hi=0, lo=0, counter=0, md_done=0, busy=0, in_ready=1 after the edge. Reset mid-operation discards the op.

Test Plan:
- WIDTH=32; a=0x8000_0001: SLL b=4 → 0x0000_0010; SRL b=36 (amount 4) → 0x0800_0000; SRA b=4 → 0xF800_0000; all same cycle, no busy.
- ADD a=0x7FFF_FFFF b=1 → result 0x8000_0000, ovf=1, neg=1. SLTU a=1 b=0xFFFF_FFFF → 1. SLT with same operands → 0.
- MULT a=−3 b=7, accepted in cycle 0 → busy cycles 1..33, md_done in cycle 33, hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. Second MULTU presented in cycle 5 stays unaccepted until cycle 34.
- DIV a=−7 b=2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU a=5 b=0 → md_done in cycle 1, lo=0xFFFF_FFFF, hi=5. DIV a=0x8000_0000 b=−1 → lo=0x8000_0000, hi=0.
- DIVU a=100 b=7 with flush asserted in cycle 10 → IDLE in cycle 11, no md_done, hi/lo unchanged. New DIVU accepted in cycle 11 completes correctly: lo=14, hi=2.
- WIDTH=8 instance: MULTU a=0xFF b=0xFF → md_done in cycle 9, hi=0xFE, lo=0x01. nRST=0 asserted in cycle 4 of a MULT → hi=lo=0, in_ready=1 next cycle.
